// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
// Contents:
//   redirect_kind_t - kind of a resolved control-flow redirect
//   DEFAULT_XLEN    - default address width
//   INSTR_BYTES     - sequential fetch stride in bytes
package pc_pkg;

    typedef enum logic [1:0] {
        JUMP = 2'd0,
        CALL = 2'd1,
        RET  = 2'd2,
        RSVD = 2'd3
    } redirect_kind_t;

    localparam int unsigned DEFAULT_XLEN = 32;
    localparam int unsigned INSTR_BYTES  = 4;

endpackage

// File: rtl/return_stack.sv
// Return-address stack used to predict return targets.
// Circular buffer: pushing when full overwrites the oldest entry, and popping
// when empty does nothing.
// Ports:
//   clk_i        - clock
//   reset_i      - asynchronous active-high reset (clears pointer and count)
//   push_i       - push push_data_i
//   pop_i        - pop top entry (ignored while push_i is high)
//   push_data_i  - return address to push
//   top_o        - entry below the pointer, 0 when empty
//   valid_o      - stack non-empty
module return_stack #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [XLEN-1:0] push_data_i,
    output logic [XLEN-1:0] top_o,
    output logic            valid_o
);

    localparam int unsigned PtrW = $clog2(RAS_DEPTH);
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0] top_idx;

    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push_i) begin
            ptr_d = ptr_q + PtrW'(1);
            if (cnt_q != CntW'(RAS_DEPTH)) begin
                cnt_d = cnt_q + CntW'(1);
            end
        end else if (pop_i && (cnt_q != '0)) begin
            ptr_d = ptr_q - PtrW'(1);
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage is never cleared; an empty stack masks it through valid_o.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[ptr_q] <= push_data_i;
        end
    end

    // Depth is a power of two, so the pointer wraps naturally.
    assign top_idx = ptr_q - PtrW'(1);
    assign valid_o = (cnt_q != '0);
    assign top_o   = valid_o ? mem_q[top_idx] : '0;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer at the head of fetch.
// Selects the next fetch address from trap entry, trap return, misaligned
// redirect (taken as a trap), resolved redirect, stall, or sequential pc + 4.
// Keeps the exception PC, a sticky misaligned flag and a return-address stack.
// Ports:
//   clk_i, reset_i     - clock, asynchronous active-high reset
//   stall_i            - hold pc this cycle
//   redirect_valid_i   - resolved control-flow change
//   redirect_kind_i    - JUMP / CALL / RET / RSVD (RSVD behaves as JUMP)
//   redirect_target_i  - resolved target address
//   trap_valid_i       - exception/interrupt entry
//   trap_return_i      - return from trap handler
//   pc_o, pc_plus4_o   - fetch address and its successor
//   epc_o              - saved exception PC
//   misaligned_o       - last trap was a misaligned redirect
//   ras_top_o          - predicted return target
//   ras_valid_o        - return stack non-empty
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned   XLEN         = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
    parameter int unsigned   RAS_DEPTH    = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [1:0]      redirect_kind_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_valid_i,
    input  logic            trap_return_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] pc_plus4_o,
    output logic [XLEN-1:0] epc_o,
    output logic            misaligned_o,
    output logic [XLEN-1:0] ras_top_o,
    output logic            ras_valid_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic            mis_q, mis_d;
    logic            ras_push, ras_pop;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4 = pc_q + XLEN'(INSTR_BYTES);

    always_comb begin
        pc_d     = pc_q;
        epc_d    = epc_q;
        mis_d    = mis_q;
        ras_push = 1'b0;
        ras_pop  = 1'b0;
        if (trap_valid_i) begin
            pc_d  = TRAP_VECTOR;
            epc_d = pc_q;
            mis_d = 1'b0;
        end else if (trap_return_i) begin
            pc_d = epc_q;
        end else if (redirect_valid_i && (redirect_target_i[1:0] != 2'b00)) begin
            // Misaligned target: enter the trap handler instead of fetching it.
            pc_d  = TRAP_VECTOR;
            epc_d = pc_q;
            mis_d = 1'b1;
        end else if (redirect_valid_i) begin
            pc_d     = redirect_target_i;
            ras_push = (redirect_kind_i == CALL);
            ras_pop  = (redirect_kind_i == RET);
        end else if (!stall_i) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pc_q  <= RESET_VECTOR;
            epc_q <= '0;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            epc_q <= epc_d;
            mis_q <= mis_d;
        end
    end

    return_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .push_i      (ras_push),
        .pop_i       (ras_pop),
        .push_data_i (pc_plus4),
        .top_o       (ras_top_o),
        .valid_o     (ras_valid_o)
    );

    assign pc_o         = pc_q;
    assign pc_plus4_o   = pc_plus4;
    assign epc_o        = epc_q;
    assign misaligned_o = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: the driver applies one request per cycle
// and queues the hand-computed state expected after the next rising edge; a
// monitor pops and compares one entry per cycle, just after the edge.
module tb_pc_sequencer;

    localparam logic [4:0] M_PC  = 5'b00001;
    localparam logic [4:0] M_EPC = 5'b00010;
    localparam logic [4:0] M_MIS = 5'b00100;
    localparam logic [4:0] M_TOP = 5'b01000;
    localparam logic [4:0] M_VLD = 5'b10000;
    localparam logic [4:0] M_ALL = 5'b11111;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        mis;
        logic [31:0] top;
        logic        vld;
        logic [4:0]  mask;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        stall_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [1:0]  redirect_kind_i = 2'd0;
    logic [31:0] redirect_target_i = '0;
    logic        trap_valid_i = 1'b0;
    logic        trap_return_i = 1'b0;
    logic [31:0] pc_o, pc_plus4_o, epc_o, ras_top_o;
    logic        misaligned_o, ras_valid_o;

    exp_t sb_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .TRAP_VECTOR  (32'h0000_0100),
        .RAS_DEPTH    (4)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .stall_i           (stall_i),
        .redirect_valid_i  (redirect_valid_i),
        .redirect_kind_i   (redirect_kind_i),
        .redirect_target_i (redirect_target_i),
        .trap_valid_i      (trap_valid_i),
        .trap_return_i     (trap_return_i),
        .pc_o              (pc_o),
        .pc_plus4_o        (pc_plus4_o),
        .epc_o             (epc_o),
        .misaligned_o      (misaligned_o),
        .ras_top_o         (ras_top_o),
        .ras_valid_o       (ras_valid_o)
    );

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", name, field, act, req);
    endtask

    task automatic check(input exp_t e);
        if (e.mask & M_PC)  cmp(e.name, "pc", pc_o, e.pc);
        if (e.mask & M_PC)  cmp(e.name, "pc_plus4", pc_plus4_o, e.pc + 32'd4);
        if (e.mask & M_EPC) cmp(e.name, "epc", epc_o, e.epc);
        if (e.mask & M_MIS) cmp(e.name, "misaligned", {31'd0, misaligned_o}, {31'd0, e.mis});
        if (e.mask & M_TOP) cmp(e.name, "ras_top", ras_top_o, e.top);
        if (e.mask & M_VLD) cmp(e.name, "ras_valid", {31'd0, ras_valid_o}, {31'd0, e.vld});
    endtask

    // Apply inputs at the current falling edge, queue the expectation for the
    // next rising edge, then advance to the following falling edge.
    task automatic step(input string name, input logic st, input logic rv,
                        input logic [1:0] kind, input logic [31:0] tgt,
                        input logic tv, input logic tr,
                        input logic [31:0] pc, input logic [31:0] epc, input logic mis,
                        input logic [31:0] top, input logic vld, input logic [4:0] mask);
        exp_t e;
        stall_i           = st;
        redirect_valid_i  = rv;
        redirect_kind_i   = kind;
        redirect_target_i = tgt;
        trap_valid_i      = tv;
        trap_return_i     = tr;
        e = '{name: name, pc: pc, epc: epc, mis: mis, top: top, vld: vld, mask: mask};
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        stall_i = 0; redirect_valid_i = 0; redirect_kind_i = 0;
        redirect_target_i = 0; trap_valid_i = 0; trap_return_i = 0;
    endtask

    // Monitor: one expectation per cycle, sampled 1 time unit after the edge.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() != 0) check(sb_q.pop_front());
        end
    end

    initial begin
        exp_t r;
        #3;
        r = '{name: "reset", pc: 0, epc: 0, mis: 0, top: 0, vld: 0, mask: M_ALL};
        check(r);
        @(negedge clk);
        reset_i = 0;

        // Free-running increment.
        step("seq1", 0, 0, 0, 0, 0, 0, 32'h4, 0, 0, 0, 0, M_ALL);
        step("seq2", 0, 0, 0, 0, 0, 0, 32'h8, 0, 0, 0, 0, M_PC);
        step("seq3", 0, 0, 0, 0, 0, 0, 32'hC, 0, 0, 0, 0, M_PC);
        step("call_pre_rst", 0, 1, 2'd1, 32'h300, 0, 0, 32'h300, 0, 0, 32'h10, 1, M_ALL);

        // Asynchronous reset between edges.
        idle_inputs();
        #2 reset_i = 1;
        #1;
        r = '{name: "async_reset", pc: 0, epc: 0, mis: 0, top: 0, vld: 0, mask: M_ALL};
        check(r);
        @(negedge clk);
        reset_i = 0;

        // Stall holds pc; a redirect overrides stall.
        step("jmp20", 0, 1, 2'd0, 32'h20, 0, 0, 32'h20, 0, 0, 0, 0, M_ALL);
        step("stall1", 1, 0, 0, 0, 0, 0, 32'h20, 0, 0, 0, 0, M_PC);
        step("stall2", 1, 0, 0, 0, 0, 0, 32'h20, 0, 0, 0, 0, M_PC);
        step("stall_jmp", 1, 1, 2'd0, 32'h80, 0, 0, 32'h80, 0, 0, 0, 0, M_PC);

        // Single call / return.
        step("jmp40", 0, 1, 2'd0, 32'h40, 0, 0, 32'h40, 0, 0, 0, 0, M_PC);
        step("call200", 0, 1, 2'd1, 32'h200, 0, 0, 32'h200, 0, 0, 32'h44, 1, M_PC | M_TOP | M_VLD);
        step("ret44", 0, 1, 2'd2, 32'h44, 0, 0, 32'h44, 0, 0, 0, 0, M_PC | M_TOP | M_VLD);

        // Overflow: five calls into a four-entry stack, then drain.
        step("jmp10", 0, 1, 2'd0, 32'h10, 0, 0, 32'h10, 0, 0, 0, 0, M_PC);
        step("call_a", 0, 1, 2'd1, 32'h20, 0, 0, 32'h20, 0, 0, 32'h14, 1, M_PC | M_TOP | M_VLD);
        step("call_b", 0, 1, 2'd1, 32'h30, 0, 0, 32'h30, 0, 0, 32'h24, 1, M_TOP | M_VLD);
        step("call_c", 0, 1, 2'd1, 32'h40, 0, 0, 32'h40, 0, 0, 32'h34, 1, M_TOP | M_VLD);
        step("call_d", 0, 1, 2'd1, 32'h50, 0, 0, 32'h50, 0, 0, 32'h44, 1, M_TOP | M_VLD);
        step("call_e", 0, 1, 2'd1, 32'h600, 0, 0, 32'h600, 0, 0, 32'h54, 1, M_PC | M_TOP | M_VLD);
        step("pop1", 0, 1, 2'd2, 32'h54, 0, 0, 32'h54, 0, 0, 32'h44, 1, M_PC | M_TOP | M_VLD);
        step("pop2", 0, 1, 2'd2, 32'h44, 0, 0, 32'h44, 0, 0, 32'h34, 1, M_TOP | M_VLD);
        step("pop3", 0, 1, 2'd2, 32'h34, 0, 0, 32'h34, 0, 0, 32'h24, 1, M_TOP | M_VLD);
        step("pop4", 0, 1, 2'd2, 32'h24, 0, 0, 32'h24, 0, 0, 0, 0, M_TOP | M_VLD);
        step("pop5", 0, 1, 2'd2, 32'h700, 0, 0, 32'h700, 0, 0, 0, 0, M_PC | M_TOP | M_VLD);

        // Misaligned redirect becomes a trap; trap return restores pc.
        step("jmp60", 0, 1, 2'd0, 32'h60, 0, 0, 32'h60, 0, 0, 0, 0, M_PC);
        step("misal", 0, 1, 2'd0, 32'h102, 0, 0, 32'h100, 32'h60, 1, 0, 0, M_ALL);
        step("tret", 0, 0, 0, 0, 0, 1, 32'h60, 32'h60, 1, 0, 0, M_ALL);

        // Trap wins over a simultaneous call and leaves the stack alone.
        step("call70", 0, 1, 2'd1, 32'h70, 0, 0, 32'h70, 32'h60, 1, 32'h64, 1, M_ALL);
        step("trap_call", 0, 1, 2'd1, 32'h400, 1, 0, 32'h100, 32'h70, 0, 32'h64, 1, M_ALL);

        // Wrap at the top of the address space.
        step("jmp_top", 0, 1, 2'd0, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'h70, 0, 0, 0, M_PC);
        step("wrap", 0, 0, 0, 0, 0, 0, 32'h0, 32'h70, 0, 32'h64, 1, M_ALL);

        idle_inputs();
        #1;
        n_total++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expectations left, expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
